// File: rtl/lock_entry_sequencer.sv
// lock_entry_sequencer
//
// Plays a parallel code word into a bit-serial combination lock, then reports
// whether the lock opened. Each attempt runs as follows:
//   1. Pulse the lock's reset pin for one cycle.
//   2. Send each code bit, MSB first. For every bit, update is held high for
//      PULSE_CYCLES cycles and then low for PULSE_CYCLES cycles. key carries
//      the bit for that whole time.
//   3. Sample the lock's unlock output.
// MAX_FAILS consecutive failed attempts start a lockout of LOCKOUT_CYCLES
// cycles. start is ignored during the lockout.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   start        request an attempt (accepted only while idle)
//   code         code word, latched when start is accepted
//   busy         attempt in progress (CLEAR through CHECK)
//   done         one-cycle pulse in the cycle after CHECK
//   granted      lock_unlock as sampled in CHECK; valid with done
//   locked_out   lockout active
//   fail_count   consecutive failed attempts
//   lock_rst     reset pin of the combination lock
//   lock_key     key pin of the combination lock
//   lock_update  update pin of the combination lock
//   lock_unlock  unlock output of the combination lock
//
// All outputs are registered. The output registers are loaded from the
// next-state decode, so each output is valid in the same cycle as the state
// it belongs to.

module lock_entry_sequencer #(
    parameter int CODE_LEN       = 5,
    parameter int PULSE_CYCLES   = 2,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CODE_LEN-1:0]            code,
    output logic                           busy,
    output logic                           done,
    output logic                           granted,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
    output logic                           lock_rst,
    output logic                           lock_key,
    output logic                           lock_update,
    input  logic                           lock_unlock
);

    localparam int FW      = $clog2(MAX_FAILS + 1);
    localparam int BW      = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int CNT_MAX = (PULSE_CYCLES > LOCKOUT_CYCLES) ? PULSE_CYCLES : LOCKOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_BIT_HI  = 3'd2;
    localparam logic [2:0] S_BIT_LO  = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_FIRST  = BW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
    localparam logic [FW-1:0] FAIL_TRIP  = FW'(MAX_FAILS - 1);

    logic [2:0]          state_r;
    logic [2:0]          state_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_s;
    logic [BW-1:0]       bit_r;
    logic [BW-1:0]       bit_s;
    logic [CODE_LEN-1:0] code_r;
    logic                accept_s;
    logic [FW-1:0]       fail_s;
    logic                key_s;
    logic                busy_s;

    // Next-state, pulse/lockout counter, bit index and fail counter decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        bit_s    = bit_r;
        accept_s = 1'b0;
        fail_s   = fail_count;
        case (state_r)
            S_IDLE: begin
                // There is no separate lockout flag to test here. The lockout
                // lives in its own state, so IDLE already means "not locked out".
                if (start) begin
                    state_s  = S_CLEAR;
                    accept_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_s = S_BIT_HI;
                cnt_s   = {CW{1'b0}};
                bit_s   = BIT_FIRST;
            end
            S_BIT_HI: begin
                if (cnt_r == PULSE_LAST) begin
                    state_s = S_BIT_LO;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            S_BIT_LO: begin
                if (cnt_r == PULSE_LAST) begin
                    cnt_s = {CW{1'b0}};
                    if (bit_r == {BW{1'b0}}) begin
                        state_s = S_CHECK;
                    end else begin
                        state_s = S_BIT_HI;
                        bit_s   = bit_r - BW'(1);
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            S_CHECK: begin
                cnt_s = {CW{1'b0}};
                if (lock_unlock) begin
                    state_s = S_IDLE;
                    fail_s  = {FW{1'b0}};
                end else begin
                    if (fail_count < FAIL_MAX) begin
                        fail_s = fail_count + FW'(1);
                    end else begin
                        fail_s = fail_count;
                    end
                    if (fail_count == FAIL_TRIP) begin
                        state_s = S_LOCKOUT;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
            end
            S_LOCKOUT: begin
                // The cycle in which LOCKOUT is entered counts as its first cycle.
                if (cnt_r == LOCK_LAST) begin
                    state_s = S_IDLE;
                    cnt_s   = {CW{1'b0}};
                    fail_s  = {FW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = {CW{1'b0}};
                bit_s   = {BW{1'b0}};
            end
        endcase
    end

    // Lock pin and busy decode, taken from the upcoming state so the registered copies line up with it.
    always_comb begin
        key_s  = 1'b0;
        busy_s = 1'b0;
        if ((state_s == S_BIT_HI) || (state_s == S_BIT_LO)) begin
            key_s = code_r[bit_s];
        end else begin
            key_s = 1'b0;
        end
        if ((state_s == S_CLEAR) || (state_s == S_BIT_HI) ||
            (state_s == S_BIT_LO) || (state_s == S_CHECK)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // State, counters, latched code and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CW{1'b0}};
            bit_r       <= {BW{1'b0}};
            code_r      <= {CODE_LEN{1'b0}};
            fail_count  <= {FW{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            granted     <= 1'b0;
            locked_out  <= 1'b0;
            lock_rst    <= 1'b0;
            lock_key    <= 1'b0;
            lock_update <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_r       <= bit_s;
            if (accept_s) begin
                code_r <= code;
            end
            fail_count  <= fail_s;
            busy        <= busy_s;
            done        <= (state_r == S_CHECK);
            granted     <= (state_r == S_CHECK) && lock_unlock;
            locked_out  <= (state_s == S_LOCKOUT);
            lock_rst    <= (state_s == S_CLEAR);
            lock_key    <= key_s;
            lock_update <= (state_s == S_BIT_HI);
        end
    end

endmodule

// File: doc/lock_entry_sequencer.md
# lock_entry_sequencer

Drives a bit-serial combination lock from a parallel code word. It resets the lock, then plays the code out one bit at a time as key/update pulses, samples the lock's unlock output, and reports grant or deny. It also counts consecutive failed attempts and enforces a timed lockout. It sits between the host/keypad logic and the combination_lock datapath, and owns that lock's key, update and reset pins exclusively.

## Interface
- CODE_LEN, 5: number of code bits per attempt.
- PULSE_CYCLES, 2: cycles `update` is held high, and then low, per bit (≥1).
- MAX_FAILS, 3: consecutive failures that trigger lockout (≥1).
- LOCKOUT_CYCLES, 16: lockout duration in cycles (≥1).

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request an attempt; sampled only in IDLE with locked_out=0.
- code  in  CODE_LEN  code word, latched on start accept; MSB sent first.
- busy  out  1  attempt in progress.
- done  out  1  one-cycle pulse, attempt finished.
- granted  out  1  valid with done; 1 means the lock reported unlock.
- locked_out  out  1  lockout active.
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failed attempts.
- lock_rst  out  1  to lock reset.
- lock_key  out  1  to lock key.
- lock_update  out  1  to lock update.
- lock_unlock  in  1  from lock unlock.

## Operation
- States:
  - IDLE: no attempt in progress.
  - CLEAR: one cycle; lock_rst=1.
  - BIT_HI: PULSE_CYCLES cycles; update=1, key=current bit.
  - BIT_LO: PULSE_CYCLES cycles; update=0, key held at current bit.
  - CHECK: one cycle; sample lock_unlock.
  - LOCKOUT: locked_out=1.
- Transitions:
  - IDLE→CLEAR on start with locked_out=0; code is latched at this point.
  - CLEAR→BIT_HI for bit CODE_LEN-1.
  - BIT_HI→BIT_LO after PULSE_CYCLES cycles.
  - BIT_LO→BIT_HI for the next lower bit, or →CHECK after bit 0.
  - CHECK→IDLE, or →LOCKOUT if the attempt failed and fail_count+1 = MAX_FAILS.
- Attempt result: done=1 in the cycle after CHECK; granted = lock_unlock as sampled in CHECK.
- Success clears fail_count to 0. Failure increments fail_count, saturating at MAX_FAILS.
- LOCKOUT:
  - Lasts LOCKOUT_CYCLES cycles, then returns to IDLE with fail_count=0 and locked_out=0.
  - start is ignored during lockout and is never queued.
- start while busy=1 is ignored; the latched code is unaffected.
- Outside BIT_HI/BIT_LO: lock_key=0, lock_update=0. lock_rst=1 only in CLEAR.
- All outputs are registered.

## Timing
- Reset value of every output is 0. State after reset is IDLE, fail_count=0. Reset mid-attempt or mid-lockout aborts immediately with no done pulse.
- Let start be sampled at edge 0 and P = PULSE_CYCLES:
  - CLEAR occupies cycle 1.
  - Bit i (i = 0 for the MSB) occupies BIT_HI in cycles 2+2Pi .. 1+2Pi+P, then BIT_LO in the following P cycles.
  - CHECK is cycle 2+2P·CODE_LEN; done is high the next cycle.
- Defaults give CHECK at cycle 22 and done at cycle 23.
- busy is high from cycle 1 through CHECK and low in the done cycle. A start in the done cycle is accepted.
- done and locked_out can both rise on the same edge when the final failure triggers lockout. The LOCKOUT_CYCLES window counts from that cycle.
- The lock samples the falling edge of update on its own negedge. P≥1 guarantees the lock's state and unlock are settled before CHECK.

## Test plan
- Correct code: code=5'b01011 → lock_update shows 5 high/low pulses with lock_key 0,1,0,1,1. done=1 and granted=1 at cycle 23; fail_count=0.
- Wrong code: code=5'b11111 → done at cycle 23 with granted=0; fail_count=1. A following 5'b01011 attempt → granted=1, fail_count=0.
- Lockout: three consecutive 5'b00000 attempts → third done has granted=0 and locked_out rises. start pulses during the next 16 cycles are ignored. locked_out falls with fail_count=0, and 5'b01011 is then granted.
- Busy rejection: second start with a different code at cycle 5 → key stream and result still match the first code; exactly one done.
- Reset mid-attempt: reset at cycle 10 → next cycle lock_update=0, busy=0, fail_count=0, and no done. A new correct attempt is granted.
- Back-to-back: start held high continuously → a new attempt begins in each done cycle; the CLEAR pulse precedes every attempt.
